// File: rtl/edge_evt_pkg.sv
// edge_evt_pkg: shared types and round-robin helper for the edge event arbiter
package edge_evt_pkg;
    localparam int MAX_CH = 32;
    typedef enum logic [1:0] {EM_OFF, EM_RISE, EM_FALL, EM_BOTH} edge_mode_t;
    typedef enum logic {ST_IDLE, ST_HOLD} arb_state_t;
    // First set bit of pend at or after ptr, wrapping at n; returns ptr when none set
    function automatic int rr_pick(input logic [MAX_CH-1:0] pend, input int ptr, input int n);
        rr_pick = ptr;
        for (int i = n - 1; i >= 0; i--)
            if (pend[(ptr + i) % n]) rr_pick = (ptr + i) % n;
    endfunction
endpackage

// File: rtl/edge_sync_detect.sv
// edge_sync_detect: per-channel synchroniser, history flop, prime gate and registered edge pulses
module edge_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic sig,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(SYNC_STAGES + 2);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic hist, s_out, primed;
    assign s_out  = sync[SYNC_STAGES-1];
    assign primed = cnt == CW'(SYNC_STAGES + 1);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
            hist <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig};
            hist <= s_out;
            cnt  <= primed ? cnt : cnt + 1'b1;
            rise <= primed & s_out & ~hist;
            fall <= primed & ~s_out & hist;
        end
    end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge detection with pending events drained
// through a round-robin valid/ready event port
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CHW        = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   sig_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CHW-1:0]    evt_ch,
    output logic              evt_rise,
    output logic [N_CH-1:0]   ovf,
    input  logic              ovf_clr
);
    logic [N_CH-1:0] det_r, det_f, acc_r, acc_f, acc, pend, pol, grant, avail, ld, ovf_set;
    logic [CHW-1:0] rr_ptr, ptr_nx, pick;
    logic hs;
    arb_state_t state;
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        edge_mode_t m;
        assign m = edge_mode_t'(mode[2*c +: 2]);
        edge_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_det (
            .clk  (clk),
            .rstn (rstn),
            .sig  (sig_in[c]),
            .rise (det_r[c]),
            .fall (det_f[c])
        );
        assign acc_r[c] = en & det_r[c] & (m == EM_RISE || m == EM_BOTH);
        assign acc_f[c] = en & det_f[c] & (m == EM_FALL || m == EM_BOTH);
        assign grant[c] = hs && evt_ch == CHW'(c);
    end
    assign hs      = evt_valid & evt_ready;
    assign acc     = acc_r | acc_f;
    // A free slot, or one being drained this cycle, takes the new polarity
    assign ld      = acc & (~pend | grant);
    assign ovf_set = acc & pend & ~grant;
    always_comb begin
        avail  = (state == ST_HOLD) ? pend & ~grant : pend;
        ptr_nx = hs ? ((evt_ch == CHW'(N_CH - 1)) ? '0 : evt_ch + 1'b1) : rr_ptr;
        pick   = CHW'(rr_pick(MAX_CH'(avail), int'(ptr_nx), N_CH));
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend <= '0;
            pol  <= '0;
            ovf  <= '0;
        end else begin
            pend <= (pend & ~grant) | acc;
            pol  <= (pol & ~ld) | (acc_r & ld);
            ovf  <= (ovf & ~{N_CH{ovf_clr}}) | ovf_set;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_rise  <= 1'b0;
            rr_ptr    <= '0;
        end else if (state == ST_IDLE || evt_ready) begin
            rr_ptr    <= ptr_nx;
            evt_valid <= |avail;
            state     <= (|avail) ? ST_HOLD : ST_IDLE;
            if (|avail) begin
                evt_ch   <= pick;
                evt_rise <= pol[pick];
            end
        end
    end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed and random stimulus against an event-level
// reference model, with a scoreboard queue of expected grants
module tb_edge_event_arbiter;
    localparam int N = 4;
    localparam int S = 2;
    logic clk = 1'b0, rstn = 1'b0, en = 1'b0, evt_ready = 1'b0, ovf_clr = 1'b0;
    logic [2*N-1:0] mode = '0;
    logic [N-1:0] sig_in = '0;
    logic evt_valid, evt_rise;
    logic [1:0] evt_ch;
    logic [N-1:0] ovf;
    int checks = 0, errors = 0;

    edge_event_arbiter #(.N_CH(N), .SYNC_STAGES(S)) dut (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .sig_in(sig_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .evt_rise(evt_rise), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; bit rise;} evt_t;
    evt_t exp_q[$];

    // Reference model: d[j] holds sig_in sampled j edges ago; an input change
    // becomes a pending event S+1 edges after it is sampled, once primed.
    logic [N-1:0] d [S+3];
    logic [N-1:0] m_pend, m_pol, m_ovf, acc, accr, grant, avail;
    int t, m_ch, m_ptr, p;
    bit m_valid, m_rise, hs;

    function automatic int first_pending(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++)
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            for (int j = 0; j < S + 3; j++) d[j] = '0;
            t = 0; m_pend = '0; m_pol = '0; m_ovf = '0;
            m_valid = 0; m_ch = 0; m_rise = 0; m_ptr = 0;
            exp_q.delete();
        end else begin
            t++;
            for (int j = S + 2; j > 0; j--) d[j] = d[j-1];
            d[0] = sig_in;
            hs = m_valid && evt_ready;
            for (int c = 0; c < N; c++) begin
                accr[c] = en && t >= S + 3 && d[S+1][c] && !d[S+2][c] && mode[2*c];
                acc[c]  = accr[c] || (en && t >= S + 3 && !d[S+1][c] && d[S+2][c] && mode[2*c+1]);
                grant[c] = hs && m_ch == c;
            end
            avail = m_valid ? m_pend & ~grant : m_pend;
            if (!m_valid || evt_ready) begin
                if (hs) m_ptr = (m_ch + 1) % N;
                p = first_pending(avail, m_ptr);
                m_valid = p >= 0;
                if (p >= 0) begin
                    m_ch = p;
                    m_rise = m_pol[p];
                    exp_q.push_back('{p, m_pol[p]});
                end
            end
            if (ovf_clr) m_ovf = '0;
            for (int c = 0; c < N; c++) begin
                if (acc[c]) begin
                    if (!m_pend[c] || grant[c]) m_pol[c] = accr[c];
                    else m_ovf[c] = 1'b1;
                    m_pend[c] = 1'b1;
                end else if (grant[c]) m_pend[c] = 1'b0;
            end
        end
    end

    evt_t e;
    always @(negedge clk) begin
        if (rstn) begin
            checks++;
            if (evt_valid !== m_valid) begin
                errors++;
                $display("FAIL valid @%0t: got %b expected %b", $time, evt_valid, m_valid);
            end
            checks++;
            if (ovf !== m_ovf) begin
                errors++;
                $display("FAIL ovf @%0t: got %b expected %b", $time, ovf, m_ovf);
            end
            if (evt_valid === 1'b1 && evt_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant @%0t: unexpected event ch=%0d rise=%b", $time, evt_ch, evt_rise);
                end else begin
                    e = exp_q.pop_front();
                    if (evt_ch !== 2'(e.ch) || evt_rise !== e.rise) begin
                        errors++;
                        $display("FAIL grant @%0t: got ch=%0d rise=%b expected ch=%0d rise=%b",
                                 $time, evt_ch, evt_rise, e.ch, e.rise);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    initial begin
        // Inputs held high through reset must not produce events
        sig_in = '1; mode = '1; en = 1'b1; evt_ready = 1'b1;
        step(3);
        expect_out("reset_out", {5'b0, evt_valid, evt_ch}, 8'h00);
        expect_out("reset_rise_ovf", {3'b0, evt_rise, ovf}, 8'h00);
        rstn = 1'b1;
        step(20);
        mode = '0; step(2); sig_in = '0; step(6);
        // Single rise on ch2: valid exactly 4 edges after sampling, one cycle wide
        mode = 8'b0101_0101;
        sig_in[2] = 1'b1;
        step(4);
        expect_out("ch2_early", {7'b0, evt_valid}, 8'h00);
        step(1);
        expect_out("ch2_event", {4'b0, evt_valid, evt_rise, evt_ch}, 8'h0e);
        step(1);
        expect_out("ch2_one_wide", {7'b0, evt_valid}, 8'h00);
        sig_in[2] = 1'b0; step(8);
        // Simultaneous rises on all channels, twice
        sig_in = '1; step(12);
        sig_in = '0; step(6);
        sig_in = '1; step(12);
        // Overflow on ch1 while the first event is held
        mode = '0; sig_in = '0; step(6);
        mode = '1; evt_ready = 1'b0;
        sig_in[1] = 1'b1; step(2);
        sig_in[1] = 1'b0; step(2);
        sig_in[1] = 1'b1; step(8);
        expect_out("ch1_held", {4'b0, evt_valid, evt_rise, evt_ch}, 8'h0d);
        expect_out("ch1_ovf", {4'b0, ovf}, 8'h02);
        evt_ready = 1'b1; step(6);
        ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
        expect_out("ovf_cleared", {4'b0, ovf}, 8'h00);
        // New ch3 edge lands on the same edge as its handshake
        evt_ready = 1'b0;
        sig_in[3] = 1'b1; step(8);
        sig_in[3] = 1'b0; step(3);
        evt_ready = 1'b1; step(1);
        evt_ready = 1'b0; step(1);
        expect_out("ch3_second", {4'b0, evt_valid, evt_rise, evt_ch}, 8'h0b);
        expect_out("ch3_no_ovf", {7'b0, ovf[3]}, 8'h00);
        evt_ready = 1'b1; step(4);
        // Disabled detection drops toggles; earlier pending event still drains
        evt_ready = 1'b0;
        sig_in[2] = 1'b1; step(8);
        en = 1'b0;
        repeat (4) begin sig_in[0] = ~sig_in[0]; step(2); end
        step(6);
        en = 1'b1; step(6);
        evt_ready = 1'b1; step(8);
        // Reset while an event is held drops it
        evt_ready = 1'b0;
        sig_in[0] = ~sig_in[0]; step(8);
        rstn = 1'b0; step(2);
        expect_out("mid_reset", {7'b0, evt_valid}, 8'h00);
        rstn = 1'b1; step(10);
        evt_ready = 1'b1; step(10);
        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) sig_in = sig_in ^ N'($urandom);
            if ($urandom_range(40) == 0) mode = 8'($urandom);
            en = $urandom_range(9) != 0;
            evt_ready = $urandom_range(2) != 0;
            ovf_clr = $urandom_range(15) == 0;
            step(1);
        end
        en = 1'b0; ovf_clr = 1'b0; evt_ready = 1'b1;
        step(20);
        expect_out("drained", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
